// File: rtl/ex_alu_stage.sv
// Execute-stage ALU with a two-entry (main + skid) registered output buffer.
// Optional build macro ALU_ILLEGAL_TRAP_EN adds an `illegal` flag for codes 110/111.
module ex_alu_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      alu_control,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            neg,
  output logic [4:0]      rd_out,
  output logic [31:0]     op_count
`ifdef ALU_ILLEGAL_TRAP_EN
  ,
  output logic            illegal
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic            zero;
    logic            neg;
    logic [4:0]      rd;
`ifdef ALU_ILLEGAL_TRAP_EN
    logic            illegal;
`endif
  } entry_t;

  state_t state, state_nxt;
  entry_t main_q, skid_q, new_entry, main_nxt;
  logic   load_main, load_skid;
  logic   in_xfer, out_xfer;
  logic   out_valid_q, in_ready_q;

  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = out_valid_q & out_ready;

  always_comb begin
    logic [XLEN-1:0] r;
    logic            ill;
    r   = '0;
    ill = 1'b0;
    case (alu_control)
      3'b000: r = src_a + src_b;
      3'b001: r = src_a - src_b;
      3'b010: r = src_a & src_b;
      3'b011: r = src_a | src_b;
      3'b100: r = src_a ^ src_b;
      3'b101: r = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: begin
`ifdef ALU_ILLEGAL_TRAP_EN
        r   = '0;
        ill = 1'b1;
`else
        r   = src_a + src_b;
`endif
      end
    endcase
    new_entry.result = r;
    new_entry.zero   = (r == '0);
    new_entry.neg    = r[XLEN-1];
    new_entry.rd     = rd_in;
`ifdef ALU_ILLEGAL_TRAP_EN
    new_entry.illegal = ill;
`endif
  end

  // Flush wins over everything; a FULL buffer never sees an input transfer.
  always_comb begin
    state_nxt = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    main_nxt  = new_entry;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            state_nxt = ONE;
            load_main = 1'b1;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            load_main = 1'b1;
          end else if (in_xfer) begin
            state_nxt = FULL;
            load_skid = 1'b1;
          end else if (out_xfer) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            state_nxt = ONE;
            load_main = 1'b1;
            main_nxt  = skid_q;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      main_q      <= '0;
      main_q.zero <= 1'b1;
      skid_q      <= '0;
      skid_q.zero <= 1'b1;
      op_count    <= '0;
    end else begin
      state       <= state_nxt;
      out_valid_q <= (state_nxt != EMPTY);
      in_ready_q  <= (state_nxt != FULL);
      if (load_main) main_q <= main_nxt;
      if (load_skid) skid_q <= new_entry;
      if (out_xfer)  op_count <= op_count + 32'd1;
    end
  end

  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
  assign result    = main_q.result;
  assign zero      = main_q.zero;
  assign neg       = main_q.neg;
  assign rd_out    = main_q.rd;
`ifdef ALU_ILLEGAL_TRAP_EN
  assign illegal   = main_q.illegal;
`endif

endmodule

// File: tb/tb_ex_alu_stage.sv
// Directed, table-driven bench for ex_alu_stage plus hand sequences for
// back-pressure, flush and asynchronous reset.
module tb_ex_alu_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alu_control;
  logic [31:0] src_a, src_b;
  logic [4:0]  rd_in;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero, neg;
  logic [4:0]  rd_out;
  logic [31:0] op_count;
`ifdef ALU_ILLEGAL_TRAP_EN
  logic        illegal;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  ex_alu_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(alu_control), .src_a(src_a), .src_b(src_b), .rd_in(rd_in),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .neg(neg), .rd_out(rd_out),
    .op_count(op_count)
`ifdef ALU_ILLEGAL_TRAP_EN
    , .illegal(illegal)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp_result;
    logic        exp_zero;
    logic        exp_neg;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[11];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [2:0] ctrl,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd);
    in_valid    = valid;
    alu_control = ctrl;
    src_a       = a;
    src_b       = b;
    rd_in       = rd;
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{3'b000, 32'd5,         32'd7,         5'd3,  32'd12,        1'b0, 1'b0, 1'b0};
    vecs[1]  = '{3'b001, 32'd7,         32'd7,         5'd4,  32'd0,         1'b1, 1'b0, 1'b0};
    vecs[2]  = '{3'b101, 32'hFFFFFFFF,  32'd1,         5'd5,  32'd1,         1'b0, 1'b0, 1'b0};
    vecs[3]  = '{3'b101, 32'd1,         32'hFFFFFFFF,  5'd6,  32'd0,         1'b1, 1'b0, 1'b0};
    vecs[4]  = '{3'b000, 32'hFFFFFFFF,  32'd1,         5'd7,  32'd0,         1'b1, 1'b0, 1'b0};
    vecs[5]  = '{3'b010, 32'hF0F0F0F0,  32'hFF00FF00,  5'd8,  32'hF000F000,  1'b0, 1'b1, 1'b0};
    vecs[6]  = '{3'b011, 32'h0F0F0000,  32'h000000F0,  5'd9,  32'h0F0F00F0,  1'b0, 1'b0, 1'b0};
    vecs[7]  = '{3'b100, 32'hFFFF0000,  32'h0F0F0F0F,  5'd10, 32'hF0F00F0F,  1'b0, 1'b1, 1'b0};
    vecs[8]  = '{3'b001, 32'd3,         32'd5,         5'd11, 32'hFFFFFFFE,  1'b0, 1'b1, 1'b0};
    vecs[9]  = '{3'b101, 32'h80000000,  32'h7FFFFFFF,  5'd12, 32'd1,         1'b0, 1'b0, 1'b0};
`ifdef ALU_ILLEGAL_TRAP_EN
    vecs[10] = '{3'b110, 32'd2,         32'd3,         5'd13, 32'd0,         1'b1, 1'b0, 1'b1};
`else
    vecs[10] = '{3'b110, 32'd2,         32'd3,         5'd13, 32'd5,         1'b0, 1'b0, 1'b0};
`endif

    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    applyStimulus(1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
    step();
    step();
    checkOutput("reset out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset in_ready",  {31'b0, in_ready},  32'd1);
    checkOutput("reset result",    result,             32'd0);
    checkOutput("reset zero",      {31'b0, zero},      32'd1);
    checkOutput("reset neg",       {31'b0, neg},       32'd0);
    checkOutput("reset rd_out",    {27'b0, rd_out},    32'd0);
    checkOutput("reset op_count",  op_count,           32'd0);
`ifdef ALU_ILLEGAL_TRAP_EN
    checkOutput("reset illegal",   {31'b0, illegal},   32'd0);
`endif
    rst = 1'b0;

    // Streaming at full throughput: each op shows up right after its edge.
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      applyStimulus(1'b1, vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].rd);
      step();
      checkOutput($sformatf("vec%0d out_valid", i), {31'b0, out_valid}, 32'd1);
      checkOutput($sformatf("vec%0d in_ready", i),  {31'b0, in_ready},  32'd1);
      checkOutput($sformatf("vec%0d result", i),    result,             vecs[i].exp_result);
      checkOutput($sformatf("vec%0d zero", i),      {31'b0, zero},      {31'b0, vecs[i].exp_zero});
      checkOutput($sformatf("vec%0d neg", i),       {31'b0, neg},       {31'b0, vecs[i].exp_neg});
      checkOutput($sformatf("vec%0d rd_out", i),    {27'b0, rd_out},    {27'b0, vecs[i].rd});
      checkOutput($sformatf("vec%0d op_count", i),  op_count,           i);
`ifdef ALU_ILLEGAL_TRAP_EN
      checkOutput($sformatf("vec%0d illegal", i),   {31'b0, illegal},   {31'b0, vecs[i].exp_ill});
`endif
    end
    applyStimulus(1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
    step();
    checkOutput("drain out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("drain op_count",  op_count,           32'd11);

    // Back-pressure: two ops fill the buffer, the third waits for space.
    out_ready = 1'b0;
    applyStimulus(1'b1, 3'b000, 32'd1, 32'd1, 5'd1);
    step();
    checkOutput("bp A result",   result,            32'd2);
    checkOutput("bp A in_ready", {31'b0, in_ready}, 32'd1);
    applyStimulus(1'b1, 3'b000, 32'd2, 32'd2, 5'd2);
    step();
    checkOutput("bp full in_ready", {31'b0, in_ready}, 32'd0);
    checkOutput("bp full result",   result,            32'd2);
    checkOutput("bp full rd_out",   {27'b0, rd_out},   32'd1);
    applyStimulus(1'b1, 3'b000, 32'd3, 32'd3, 5'd3);
    step();
    checkOutput("bp hold result",    result,             32'd2);
    checkOutput("bp hold out_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("bp hold in_ready",  {31'b0, in_ready},  32'd0);
    out_ready = 1'b1;
    step();
    checkOutput("bp B result",   result,            32'd4);
    checkOutput("bp B rd_out",   {27'b0, rd_out},   32'd2);
    checkOutput("bp B in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("bp B op_count", op_count,          32'd12);
    step();
    applyStimulus(1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
    checkOutput("bp C result",   result,          32'd6);
    checkOutput("bp C rd_out",   {27'b0, rd_out}, 32'd3);
    checkOutput("bp C op_count", op_count,        32'd13);
    step();
    checkOutput("bp end out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("bp end op_count",  op_count,           32'd14);

    // Flush in FULL with a simultaneous input: everything is discarded.
    out_ready = 1'b0;
    applyStimulus(1'b1, 3'b000, 32'd10, 32'd0, 5'd5);
    step();
    applyStimulus(1'b1, 3'b000, 32'd10, 32'd10, 5'd6);
    step();
    checkOutput("pre-flush in_ready", {31'b0, in_ready}, 32'd0);
    flush = 1'b1;
    applyStimulus(1'b1, 3'b000, 32'd99, 32'd1, 5'd7);
    step();
    flush = 1'b0;
    applyStimulus(1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
    checkOutput("flush out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("flush in_ready",  {31'b0, in_ready},  32'd1);
    out_ready = 1'b1;
    step();
    checkOutput("post-flush out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("post-flush op_count",  op_count,           32'd14);

    // Flush coinciding with an output handshake still counts the transfer.
    out_ready = 1'b0;
    applyStimulus(1'b1, 3'b000, 32'd4, 32'd4, 5'd8);
    step();
    applyStimulus(1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
    checkOutput("flush-out result", result, 32'd8);
    out_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    checkOutput("flush-out out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("flush-out op_count",  op_count,           32'd15);

    // Asynchronous reset between edges while ONE.
    out_ready = 1'b0;
    applyStimulus(1'b1, 3'b000, 32'd1, 32'd2, 5'd9);
    step();
    applyStimulus(1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
    checkOutput("pre-rst out_valid", {31'b0, out_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async rst out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("async rst op_count",  op_count,           32'd0);
    checkOutput("async rst in_ready",  {31'b0, in_ready},  32'd1);
    checkOutput("async rst result",    result,             32'd0);
    #1;
    rst = 1'b0;
    step();
    checkOutput("post-rst out_valid", {31'b0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
